// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier control unit.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

  localparam int N_BITS_DEFAULT = 8;

  // True on the final iteration, where the partial product is subtracted.
  function automatic logic last_iter(input int unsigned k, input int unsigned n_bits);
    return (k == (n_bits - 32'd1));
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier: cleared in CLR, stepped after each
// non-final SHIFT, and flags the last iteration.
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEFAULT,
  localparam int KW    = $clog2(N_BITS)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clear,
  input  logic          inc,
  output logic [KW-1:0] k,
  output logic          last
);

  logic [KW-1:0] k_q;
  logic [KW-1:0] k_d;

  // Next count: clear has priority over increment.
  always_comb begin
    k_d = k_q;
    if (clear) begin
      k_d = '0;
    end else if (inc) begin
      k_d = k_q + {{(KW-1){1'b0}}, 1'b1};
    end else begin
      k_d = k_q;
    end
  end

  // Count register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k    = k_q;
  assign last = last_iter(32'(k_q), N_BITS);

endmodule

// File: rtl/mult_control_unit.sv
// Control FSM for the signed shift-add multiplier. Optional input
// synchronizers on Run/ClearA_LoadB_In are enabled with RUN_SYNC_EN.
module mult_control_unit
  import mult_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB_In,
  input  logic M,
  output logic ClearA_LoadB,
  output logic ClearA,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int KW = $clog2(N_BITS);

  mult_state_t   state_q;
  logic          run_s;
  logic          cl_in_s;
  logic [KW-1:0] k_s;
  logic          last_s;

`ifdef RUN_SYNC_EN
  logic run_meta_q;
  logic run_sync_q;
  logic cl_meta_q;
  logic cl_sync_q;

  // Two-flop synchronizers for the asynchronous button levels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_meta_q <= 1'b0;
      run_sync_q <= 1'b0;
      cl_meta_q  <= 1'b0;
      cl_sync_q  <= 1'b0;
    end else begin
      run_meta_q <= Run;
      run_sync_q <= run_meta_q;
      cl_meta_q  <= ClearA_LoadB_In;
      cl_sync_q  <= cl_meta_q;
    end
  end

  assign run_s   = run_sync_q;
  assign cl_in_s = cl_sync_q;
`else
  assign run_s   = Run;
  assign cl_in_s = ClearA_LoadB_In;
`endif

  mult_iter_counter #(
    .N_BITS (N_BITS)
  ) u_iter_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (state_q == CLR),
    .inc   ((state_q == SHIFT) && !last_s),
    .k     (k_s),
    .last  (last_s)
  );

  // State register and transitions; load request wins over Run in IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cl_in_s) begin
            state_q <= IDLE;
          end else if (run_s) begin
            state_q <= CLR;
          end else begin
            state_q <= IDLE;
          end
        end
        CLR:   state_q <= ADD;
        ADD:   state_q <= SHIFT;
        SHIFT: state_q <= last_s ? DONE : ADD;
        DONE:  state_q <= run_s ? DONE : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode: strobes follow the state register; Add/Sub also follow M.
  always_comb begin
    ClearA_LoadB = 1'b0;
    ClearA       = 1'b0;
    Add          = 1'b0;
    Sub          = 1'b0;
    Shift_En     = 1'b0;
    Busy         = 1'b0;
    Done         = 1'b0;
    case (state_q)
      IDLE: ClearA_LoadB = cl_in_s;
      CLR: begin
        ClearA = 1'b1;
        Busy   = 1'b1;
      end
      ADD: begin
        Busy = 1'b1;
        if (last_s) begin
          Sub = M;
        end else begin
          Add = M;
        end
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: Busy = 1'b0;
    endcase
  end

endmodule

// File: doc/mult_control_unit.md
Name: mult_control_unit

Overview:
- Control FSM for the 8-bit shift-add multiplier datapath; sits directly upstream of the X/A/B register.
- Converts the Run and ClearA_LoadB button levels into per-cycle strobes: ClearA_LoadB, ClearA, Add, Sub, Shift_En.
- Samples M (current B[0]) to decide add, subtract or skip on each iteration.
- Final iteration subtracts, giving signed two's-complement multiplication.

Parameters:
N_BITS, 8, multiplicand/multiplier width; number of add-shift iterations.

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Run  in  1  level; start a multiply (button, active-high)
ClearA_LoadB_In  in  1  level; request clear A/X and load B from switches
M  in  1  current LSB of B, driven by the datapath
ClearA_LoadB  out  1  strobe to datapath: clear A and X, load B
ClearA  out  1  strobe: clear A and X, B kept
Add  out  1  strobe: X:A <= sext(A + S)
Sub  out  1  strobe: X:A <= sext(A - S)
Shift_En  out  1  strobe: arithmetic right shift of X:A:B
Busy  out  1  high from CLR through last SHIFT
Done  out  1  high in DONE

Behaviour:
- Reset (synchronous, active-high, Clk rising edge):
  - state <= IDLE, iteration counter <= 0.
  - All outputs 0 in the following cycle. Applies mid-operation too; no partial strobes after the reset edge.
- States: IDLE, CLR, ADD, SHIFT, DONE. Counter k is $clog2(N_BITS) bits wide and counts 0..N_BITS-1.
- IDLE:
  - ClearA_LoadB = ClearA_LoadB_In, combinational, level.
  - If ClearA_LoadB_In=1, stay in IDLE; it has priority over Run.
  - Else if Run=1, go to CLR.
- CLR: ClearA=1 for exactly one cycle; k <= 0; go to ADD.
- ADD:
  - If k < N_BITS-1: Add = M.
  - If k == N_BITS-1: Sub = M.
  - Add and Sub are never both 1. Outputs are combinational from state, k and M (Mealy on M only).
  - Go to SHIFT.
- SHIFT: Shift_En=1 for one cycle.
  - If k == N_BITS-1: go to DONE.
  - Else k <= k+1 and go to ADD.
- DONE:
  - Done=1.
  - Hold while Run=1; Run held high never restarts a multiply.
  - Go to IDLE when Run=0; Done=0 in that next cycle.
  - ClearA_LoadB_In is ignored in DONE.
- Latency:
  - Run sampled high at edge 0 puts CLR in cycle 1.
  - ADD/SHIFT pairs occupy cycles 2..2*N_BITS+1.
  - Done=1 from cycle 2*N_BITS+2 (cycle 18 for N_BITS=8).
  - Exactly N_BITS Shift_En pulses per multiply.
- Busy=1 in CLR, ADD and SHIFT; 0 in IDLE and DONE.
- Strobe exclusivity: at most one of ClearA_LoadB, ClearA, Add, Sub, Shift_En is high in any cycle.
- ClearA_LoadB_In and Run changes during CLR/ADD/SHIFT are ignored.
- If Run is still high when the block returns to IDLE (e.g. after reset), a new multiply starts.

Optional Feature:
- Macro RUN_SYNC_EN.
- Defined:
  - Run and ClearA_LoadB_In each pass through a two-flop synchronizer; flops are reset to 0 by Reset.
  - The FSM sees the synchronized versions, adding 2 cycles to every latency above (Done at cycle 20 for N_BITS=8).
- Undefined:
  - Inputs are used directly.
  - Callers must guarantee the inputs are synchronous to Clk.

Decomposition:
- Package mult_pkg holds:
  - state enum mult_state_t {IDLE, CLR, ADD, SHIFT, DONE};
  - localparam N_BITS_DEFAULT = 8;
  - function last_iter(k) returning k == N_BITS-1.
- One sub-module: mult_iter_counter.
  - Ports: Clk, Reset, clear, inc; outputs k and last.
  - Instantiated once.
  - Synchronizer flops stay inline under the macro.

Test Plan:
- Reset held 2 cycles from random state, then released with Run=0 -> all outputs 0, Busy=0, Done=0.
- IDLE, ClearA_LoadB_In=1 for 1 cycle -> ClearA_LoadB=1 for that cycle only; no other strobe; FSM stays in IDLE.
- Run=1 with M=1 every cycle -> ClearA at cycle 1; Add at cycles 2,4,...,14; Sub at cycle 16; 8 Shift_En pulses on odd cycles 3..17; Done=1 at cycle 18.
- Run=1 with M=0 throughout -> no Add/Sub pulses, 8 Shift_En pulses, Done at cycle 18; Run held high 10 more cycles -> Done stays 1, no strobes; Run=0 -> IDLE next cycle, Done=0.
- Run=1 and ClearA_LoadB_In=1 together in IDLE -> ClearA_LoadB=1, no CLR; then drop ClearA_LoadB_In -> CLR next cycle.
- Reset at cycle 7 mid-multiply, Run=0 -> all outputs 0 the next cycle; FSM idle; counter restarts at 0 on the next Run (Done at 18 cycles after the new Run).
